// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encodings, parity-mode names and
// the baud divisor helpers used by uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        CHECK = 5'b01000,
        STOP  = 5'b10000
    } uart_state_e;

    localparam string PARITY_NONE = "None";
    localparam string PARITY_ODD  = "Odd";
    localparam string PARITY_EVEN = "Even";

    localparam int CNT_W = 20;

    // Truncating divide; no fractional baud correction is attempted.
    function automatic logic [CNT_W-1:0] calc_bit_cyc(input int unsigned clock,
                                                      input int unsigned baud);
        int unsigned q;
        q = clock / baud;
        return q[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] calc_half_cyc(input int unsigned clock,
                                                       input int unsigned baud);
        return calc_bit_cyc(clock, baud) >> 1;
    endfunction

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser and falling-edge detector for the raw rx line.
// With UART_RX_MAJORITY_EN defined, rx_s is the majority of the last 3 synchronised values.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    // Flops reset to 1 so an idle-high line produces no edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

`ifdef UART_RX_MAJORITY_EN
    logic rx_prev2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev2_q <= 1'b1;
        end else begin
            rx_prev2_q <= rx_prev_q;
        end
    end

    assign rx_s = maj3({rx_sync_q, rx_prev_q, rx_prev2_q});
`else
    assign rx_s = rx_sync_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB first, optional parity, 1 stop bit.
// Optional majority-vote sampling is enabled with the UART_RX_MAJORITY_EN macro.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [25:0] CLOCK     = 26'd50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter string       CHECK_BIT = "None"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_data_vld,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy,
    output uart_state_e state_dbg
);

    localparam logic [CNT_W-1:0] BIT_CYC   = calc_bit_cyc(32'(CLOCK), BAUD);
    localparam logic [CNT_W-1:0] HALF_CYC  = calc_half_cyc(32'(CLOCK), BAUD);
    localparam logic [CNT_W-1:0] BIT_LAST  = BIT_CYC - 20'd1;
    localparam logic [CNT_W-1:0] HALF_LAST = HALF_CYC - 20'd1;
    localparam bit               PAR_EN    = (CHECK_BIT != PARITY_NONE);
    localparam bit               PAR_ODD   = (CHECK_BIT == PARITY_ODD);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    uart_state_e      state_q,    state_d;
    logic [CNT_W-1:0] cnt_baud_q, cnt_baud_d;
    logic [2:0]       cnt_bit_q,  cnt_bit_d;
    logic [7:0]       shift_q,    shift_d;
    logic             par_bad_q,  par_bad_d;
    logic [7:0]       data_q,     data_d;
    logic             vld_q,      vld_d;
    logic             perr_q,     perr_d;
    logic             ferr_q,     ferr_d;
    logic             bit_end;
    logic             half_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_baud_q <= '0;
            cnt_bit_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_baud_q <= cnt_baud_d;
            cnt_bit_q  <= cnt_bit_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bit_end  = (cnt_baud_q == BIT_LAST);
    assign half_end = (cnt_baud_q == HALF_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_baud_d = cnt_baud_q;
        cnt_bit_d  = cnt_bit_q;
        shift_d    = shift_q;
        par_bad_d  = par_bad_q;
        data_d     = data_q;
        vld_d      = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_baud_d = '0;
                cnt_bit_d  = '0;
                if (rx_fall) begin
                    state_d   = START;
                    par_bad_d = 1'b0;
                end
            end

            // A line that is high again at mid start bit was a glitch.
            START: begin
                if (half_end) begin
                    cnt_baud_d = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end else begin
                    cnt_baud_d = cnt_baud_q + 20'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_baud_d = '0;
                    shift_d    = {rx_s, shift_q[7:1]};
                    cnt_bit_d  = cnt_bit_q + 3'd1;
                    if (cnt_bit_q == 3'd7) begin
                        state_d = PAR_EN ? CHECK : STOP;
                    end
                end else begin
                    cnt_baud_d = cnt_baud_q + 20'd1;
                end
            end

            CHECK: begin
                if (bit_end) begin
                    cnt_baud_d = '0;
                    par_bad_d  = PAR_ODD ? ~(^shift_q ^ rx_s) : (^shift_q ^ rx_s);
                    state_d    = STOP;
                end else begin
                    cnt_baud_d = cnt_baud_q + 20'd1;
                end
            end

            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
            STOP: begin
                if (bit_end) begin
                    cnt_baud_d = '0;
                    state_d    = IDLE;
                    vld_d      = 1'b1;
                    data_d     = shift_q;
                    perr_d     = par_bad_q & PAR_EN;
                    ferr_d     = ~rx_s;
                end else begin
                    cnt_baud_d = cnt_baud_q + 20'd1;
                end
            end

            default: begin
                state_d    = IDLE;
                cnt_baud_d = '0;
                cnt_bit_d  = '0;
            end
        endcase
    end

    // rx_data_vld is a one-cycle push with no ready: the consumer must accept it
    // that cycle; flags are meaningful only alongside it and are 0 otherwise.
    assign rx_data     = data_q;
    assign rx_data_vld = vld_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one no-parity receiver and Odd/Even receivers sharing a parity line.
module tb_uart_rx;
    import uart_pkg::*;

    localparam logic [25:0] CLK_HZ = 26'd1_000_000;
    localparam int unsigned BAUD   = 31250;
    localparam int          BIT    = 32;
    localparam int          HALF   = 16;
    localparam int          NO_GL  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_n = 1'b1;
    logic rx_p = 1'b1;

    logic [7:0] data_n, data_o, data_e;
    logic vld_n, vld_o, vld_e;
    logic perr_n, perr_o, perr_e;
    logic ferr_n, ferr_o, ferr_e;
    logic busy_n, busy_o, busy_e;
    uart_state_e st_n, st_o, st_e;

    int n_assert = 0;
    int n_fail = 0;
    int stray_cnt = 0;
    int busy_cyc_n = 0;
    int busy_cyc_o = 0;

    // {parity_err, frame_err, rx_data} for every vld pulse
    logic [9:0] got_n_q[$];
    logic [9:0] got_o_q[$];
    logic [9:0] got_e_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLOCK(CLK_HZ), .BAUD(BAUD), .CHECK_BIT("None")) dut_n (
        .clk(clk), .rst(rst), .rx(rx_n), .rx_data(data_n), .rx_data_vld(vld_n),
        .parity_err(perr_n), .frame_err(ferr_n), .busy(busy_n), .state_dbg(st_n)
    );

    uart_rx #(.CLOCK(CLK_HZ), .BAUD(BAUD), .CHECK_BIT("Odd")) dut_o (
        .clk(clk), .rst(rst), .rx(rx_p), .rx_data(data_o), .rx_data_vld(vld_o),
        .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o), .state_dbg(st_o)
    );

    uart_rx #(.CLOCK(CLK_HZ), .BAUD(BAUD), .CHECK_BIT("Even")) dut_e (
        .clk(clk), .rst(rst), .rx(rx_p), .rx_data(data_e), .rx_data_vld(vld_e),
        .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e), .state_dbg(st_e)
    );

    always @(negedge clk) begin
        if (vld_n) got_n_q.push_back({perr_n, ferr_n, data_n});
        if (vld_o) got_o_q.push_back({perr_o, ferr_o, data_o});
        if (vld_e) got_e_q.push_back({perr_e, ferr_e, data_e});
        if (!vld_n && (perr_n || ferr_n)) stray_cnt++;
        if (!vld_o && (perr_o || ferr_o)) stray_cnt++;
        if (!vld_e && (perr_e || ferr_e)) stray_cnt++;
        if (busy_n) busy_cyc_n++;
        if (busy_o) busy_cyc_o++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit par_line, input logic v, input int cyc);
        if (par_line) rx_p = v;
        else rx_n = v;
        repeat (cyc) @(negedge clk);
    endtask

    // glitch_bit selects a data bit that gets a 1-clk inversion near its centre
    task automatic send_frame(input bit par_line, input logic [7:0] d, input logic par,
                              input logic stop, input int glitch_bit);
        drive(par_line, 1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(par_line, d[i], HALF + 2);
                drive(par_line, ~d[i], 1);
                drive(par_line, d[i], BIT - HALF - 3);
            end else begin
                drive(par_line, d[i], BIT);
            end
        end
        if (par_line) drive(1'b1, par, BIT);
        drive(par_line, stop, BIT);
    endtask

    task automatic expect_frame(input string tag, input int which, input logic [9:0] exp);
        logic [9:0] got;
        got = 'x;
        if (which == 0 && got_n_q.size() > 0) got = got_n_q.pop_front();
        if (which == 1 && got_o_q.size() > 0) got = got_o_q.pop_front();
        if (which == 2 && got_e_q.size() > 0) got = got_e_q.pop_front();
        chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        int b0;
        int bo;

        // reset state
        idle(3);
        chk("rst_data", 32'(data_n), 32'h0);
        chk("rst_vld", 32'(vld_n), 32'h0);
        chk("rst_busy", 32'(busy_n), 32'h0);
        chk("rst_state", 32'(st_n), 32'(IDLE));
        chk("rst_perr_o", 32'(perr_o), 32'h0);
        rst = 1'b0;
        idle(4);
        chk("post_rst_busy", 32'(busy_o), 32'h0);

        // 1: clean 0x55, no parity
        b0 = busy_cyc_n;
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, NO_GL);
        idle(4);
        expect_frame("t1_frame", 0, {2'b00, 8'h55});
        chk("t1_busy_cycles", 32'(busy_cyc_n - b0), 32'(HALF + 9 * BIT));
        chk("t1_busy_end", 32'(busy_n), 32'h0);
        idle(BIT);
        chk("t1_data_held", 32'(data_n), 32'h55);

        // 2: 0xA5 with parity 1 (good for Odd, bad for Even), then parity 0
        bo = busy_cyc_o;
        send_frame(1'b1, 8'hA5, 1'b1, 1'b1, NO_GL);
        idle(4);
        expect_frame("t2_odd_p1", 1, {2'b00, 8'hA5});
        expect_frame("t2_even_p1", 2, {2'b10, 8'hA5});
        chk("t2_busy_cycles", 32'(busy_cyc_o - bo), 32'(HALF + 10 * BIT));
        send_frame(1'b1, 8'hA5, 1'b0, 1'b1, NO_GL);
        idle(4);
        expect_frame("t2_odd_p0", 1, {2'b10, 8'hA5});
        expect_frame("t2_even_p0", 2, {2'b00, 8'hA5});

        // 3: bad stop bit, then a clean frame
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, NO_GL);
        rx_n = 1'b1;
        idle(2 * BIT);
        expect_frame("t3_frame_err", 0, {2'b01, 8'h3C});
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, NO_GL);
        idle(4);
        expect_frame("t3_recover", 0, {2'b00, 8'h81});

        // 4: short low glitch is rejected as a false start
        b0 = busy_cyc_n;
        drive(1'b0, 1'b0, 8);
        drive(1'b0, 1'b1, 2 * BIT);
        chk("t4_busy_cycles", 32'(busy_cyc_n - b0), 32'(HALF));
        chk("t4_busy", 32'(busy_n), 32'h0);
        chk("t4_state", 32'(st_n), 32'(IDLE));
        chk("t4_no_vld", 32'(got_n_q.size()), 32'h0);

        // 5: back-to-back frames with one stop bit between
        send_frame(1'b0, 8'h00, 1'b0, 1'b1, NO_GL);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1, NO_GL);
        idle(4);
        chk("t5_count", 32'(got_n_q.size()), 32'h2);
        expect_frame("t5_first", 0, {2'b00, 8'h00});
        expect_frame("t5_second", 0, {2'b00, 8'hFF});

        // 6: reset in the middle of data bit 4 of 0x5A
        drive(1'b0, 1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b0, (8'h5A >> i) & 8'h01, BIT);
        drive(1'b0, 1'b1, HALF);
        chk("t6_busy_before", 32'(busy_n), 32'h1);
        rst = 1'b1;
        rx_n = 1'b1;
        idle(1);
        chk("t6_rst_busy", 32'(busy_n), 32'h0);
        chk("t6_rst_state", 32'(st_n), 32'(IDLE));
        chk("t6_rst_data", 32'(data_n), 32'h0);
        chk("t6_rst_vld", 32'(vld_n), 32'h0);
        idle(3);
        rst = 1'b0;
        idle(2 * BIT);
        chk("t6_no_vld", 32'(got_n_q.size()), 32'h0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, NO_GL);
        idle(4);
        expect_frame("t6_after_rst", 0, {2'b00, 8'hC3});

`ifdef UART_RX_MAJORITY_EN
        // 1-clk glitch near a mid-bit sample is voted out
        send_frame(1'b0, 8'h55, 1'b0, 1'b1, 3);
        idle(4);
        expect_frame("maj_glitch", 0, {2'b00, 8'h55});
        send_frame(1'b1, 8'h96, 1'b1, 1'b1, 6);
        idle(4);
        expect_frame("maj_glitch_odd", 1, {2'b00, 8'h96});
`endif

        idle(BIT);
        chk("end_stray_flags", 32'(stray_cnt), 32'h0);
        chk("end_q_n", 32'(got_n_q.size()), 32'h0);
        chk("end_q_o", 32'(got_o_q.size()), 32'h0);
        chk("end_q_e", 32'(got_e_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
